// File: rtl/handshake_fifo.sv
// handshake_fifo: valid/ready FIFO with registered occupancy and almost-full.
// Outputs come from state only; flush and rst clear occupancy, not storage.
module handshake_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       afull
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);
  localparam logic [CW-1:0] AFC   = CW'(AFULL_LVL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             af_q;
  logic             rdy_en;
  logic             push;
  logic             pop;

  // rdy_en holds in_ready low until the first edge after reset release
  assign in_ready  = rdy_en & (cnt_q != FULLC) & ~flush;
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem[rptr];
  assign count     = cnt_q;
  assign afull     = af_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      flush:       cnt_d = '0;
      push & ~pop: cnt_d = cnt_q + CW'(1);
      pop & ~push: cnt_d = cnt_q - CW'(1);
      default:     cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt_q  <= '0;
      af_q   <= 1'b0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      cnt_q  <= cnt_d;
      af_q   <= (cnt_d >= AFC);
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + AW'(1);
        if (pop)  rptr <= rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

endmodule

// File: tb/tb_handshake_fifo.sv
// tb_handshake_fifo: directed vector table plus streaming and reset sequences.
// Each vector's expectations are the outputs seen before its clock edge.
module tb_handshake_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       afull;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  handshake_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count),
    .afull(afull)
  );

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic       orr;
    logic [2:0] cnt;
    logic       ir;
    logic       ov;
    logic [7:0] od;
    logic       af;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, input logic iv, input logic [7:0] d,
                     input logic orr, input logic [2:0] cnt, input logic ir,
                     input logic ov, input logic [7:0] od, input logic af);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.orr = orr;
    v.cnt = cnt; v.ir = ir; v.ov = ov; v.od = od; v.af = af;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [7:0] d,
                       input logic orr);
    flush = fl; in_valid = iv; in_data = d; out_ready = orr;
  endtask

  logic [7:0] q[$];
  logic [7:0] nd;

  initial begin
    //  fl iv data  or  cnt ir ov data  af
    // fill to full under backpressure, then drain
    add(0, 1, 8'hA0, 0, 0, 1, 0, 8'h00, 0);
    add(0, 1, 8'hA1, 0, 1, 1, 1, 8'hA0, 0);
    add(0, 1, 8'hA2, 0, 2, 1, 1, 8'hA0, 0);
    add(0, 1, 8'hA3, 0, 3, 1, 1, 8'hA0, 1);
    add(0, 1, 8'hEE, 0, 4, 0, 1, 8'hA0, 1);
    add(0, 0, 8'h00, 1, 4, 0, 1, 8'hA0, 1);
    add(0, 0, 8'h00, 1, 3, 1, 1, 8'hA1, 1);
    add(0, 0, 8'h00, 1, 2, 1, 1, 8'hA2, 0);
    add(0, 0, 8'h00, 1, 1, 1, 1, 8'hA3, 0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
    // empty: push with out_ready set is push only, one-cycle latency
    add(0, 1, 8'h55, 1, 0, 1, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 1, 1, 1, 8'h55, 0);
    add(0, 0, 8'h00, 1, 1, 1, 1, 8'h55, 0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
    // full with pop: pop only, then push and pop together
    add(0, 1, 8'hB0, 0, 0, 1, 0, 8'h00, 0);
    add(0, 1, 8'hB1, 0, 1, 1, 1, 8'hB0, 0);
    add(0, 1, 8'hB2, 0, 2, 1, 1, 8'hB0, 0);
    add(0, 1, 8'hB3, 0, 3, 1, 1, 8'hB0, 1);
    add(0, 1, 8'hC0, 1, 4, 0, 1, 8'hB0, 1);
    add(0, 1, 8'hC0, 1, 3, 1, 1, 8'hB1, 1);
    add(0, 0, 8'h00, 0, 3, 1, 1, 8'hB2, 1);
    // flush overrides an offered word
    add(1, 1, 8'hDD, 0, 3, 0, 1, 8'hB2, 1);
    add(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
    add(0, 1, 8'h11, 0, 0, 1, 0, 8'h00, 0);
    add(0, 0, 8'h00, 0, 1, 1, 1, 8'h11, 0);
    add(0, 0, 8'h00, 1, 1, 1, 1, 8'h11, 0);
    add(0, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0);

    rst = 1'b0;
    drive(0, 0, 8'h00, 0);
    #3;
    chk("rst_count", 32'(count), 0);
    chk("rst_ovalid", 32'(out_valid), 0);
    chk("rst_afull", 32'(afull), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("ready_after_rst", 32'(in_ready), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].orr);
      #1;
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_iready", i), 32'(in_ready), 32'(vecs[i].ir));
      chk($sformatf("v%0d_ovalid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("v%0d_afull", i), 32'(afull), 32'(vecs[i].af));
      if (vecs[i].ov)
        chk($sformatf("v%0d_odata", i), 32'(out_data), 32'(vecs[i].od));
      @(posedge clk);
    end

    // streaming at count=2 for 20 words; pointers wrap five times
    @(negedge clk);
    drive(0, 1, 8'h30, 0);
    @(negedge clk);
    drive(0, 1, 8'h31, 0);
    q.push_back(8'h30);
    q.push_back(8'h31);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      nd = 8'h40 + 8'(i);
      drive(0, 1, nd, 1);
      #1;
      chk($sformatf("s%0d_count", i), 32'(count), 2);
      chk($sformatf("s%0d_odata", i), 32'(out_data), 32'(q[0]));
      @(posedge clk);
      void'(q.pop_front());
      q.push_back(nd);
    end
    @(negedge clk);
    drive(0, 0, 8'h00, 0);
    #1;
    chk("s_end_count", 32'(count), 2);
    chk("s_end_odata", 32'(out_data), 32'(q[0]));

    // async reset mid-transfer discards contents
    #1;
    rst = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_ovalid", 32'(out_valid), 0);
    chk("ar_afull", 32'(afull), 0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("ar_iready", 32'(in_ready), 1);
    chk("ar_empty", 32'(out_valid), 0);
    drive(0, 1, 8'h77, 0);
    @(negedge clk);
    drive(0, 0, 8'h00, 0);
    #1;
    chk("ar_ovalid2", 32'(out_valid), 1);
    chk("ar_odata", 32'(out_data), 32'h77);
    chk("ar_count2", 32'(count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/handshake_fifo.md
HANDSHAKE_FIFO -- requirements
Module: handshake_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the payload width in bits (legal values 1 or more).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of storage entries (power of 2, 2 or more).
REQ-003 The block SHALL have parameter AFULL_LVL, default DEPTH-1, meaning the occupancy at which afull asserts (legal range 1..DEPTH).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous clear of all stored entries.
REQ-007 The block SHALL have port in_valid, input, 1 bit: the producer offers in_data.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: producer payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data holds the oldest entry.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_data this cycle.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: consumer payload.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-014 The block SHALL have port afull, output, 1 bit: asserted when count is AFULL_LVL or more.

Function
REQ-015 A push SHALL occur on a cycle with in_valid=1, in_ready=1 and flush=0; a pop SHALL occur on a cycle with out_valid=1, out_ready=1 and flush=0.
REQ-016 in_ready SHALL equal (count<DEPTH) and not flush; it SHALL be driven from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (count>0); out_data SHALL be the oldest unpopped entry and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 Latency: a word pushed into an empty FIFO SHALL appear on out_valid/out_data on the next rising edge; there is no same-cycle fall-through.
REQ-019 Ordering SHALL be strict FIFO; no word is dropped or duplicated.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-021 When full, in_ready=0 and no push occurs even if a pop happens in the same cycle; the freed slot becomes available the following cycle.
REQ-022 When empty, a push and an out_ready=1 in the same cycle SHALL result in a push only.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 without a gap.
REQ-024 count SHALL be incremented on a push-only cycle, decremented on a pop-only cycle, and held otherwise; it never exceeds DEPTH and never goes below 0.
REQ-025 flush=1 SHALL, at the next edge, set count=0 and both pointers to 0; it overrides any push or pop in that cycle.
REQ-026 afull SHALL be a registered function of count and updated in the same edge as count.
REQ-027 Storage contents SHALL NOT require reset; out_data is don't-care while out_valid=0.

Reset
REQ-028 rst=0 SHALL immediately force count=0, both pointers to 0, out_valid=0 and afull=0; in_ready SHALL be 1 from the first edge after rst is deasserted.
REQ-029 Assertion of rst mid-transfer SHALL discard all stored entries; no stale word appears after reset is released.

Verification
REQ-030 Fill and drain: DEPTH=4; push 0xA0..0xA3 with out_ready=0 -> count=4, in_ready=0, afull=1 from count 3; then out_ready=1 -> 0xA0..0xA3 emerge in order on 4 consecutive cycles.
REQ-031 Latency: push 0x55 into an empty FIFO at edge N -> out_valid=1 with out_data=0x55 after edge N, and out_valid=0 at edge N itself.
REQ-032 Streaming: in_valid=out_ready=1 continuously for 20 words with count=2 -> count stays 2, one word per cycle out, and the pointers wrap at least 4 times.
REQ-033 Full with pop: count=4, in_valid=1, out_ready=1 -> that cycle only pops (count=3); the next cycle has push and pop together (count=3).
REQ-034 Flush: count=3, flush=1 together with in_valid=1 -> count=0, out_valid=0 next cycle, and the offered word is not stored.
REQ-035 Reset: count=2, rst=0 pulsed asynchronously between edges -> count=0 and out_valid=0 immediately; after release, pushing 0x77 yields 0x77 as the first output word.
